uart_tx_periph: RTL and testbench
=================================

Name: uart_tx_periph

Overview:
Memory-mapped UART transmitter on the data-side peripheral bus. It is enabled by the peripheral bus's cs_uart chip select and is addressed by word offset.
- Byte writes from the core are buffered in a small TX FIFO.
- Bytes are serialised as 8N1 frames on tx_o at a programmable baud divisor.
- Status and divisor are readable so firmware can poll before writing.

Parameters:
DW, 32, bus data width
FIFO_DEPTH, 4, TX FIFO entries (power of two, >=2)
DEFAULT_DIV, 868, reset value of BAUD_DIV in clocks per bit (100 MHz / 115200)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
cs_i  input  1  chip select from peripheral bus (cs_uart)
we_i  input  1  store strobe, qualified by cs_i
addr_i  input  2  word offset inside UART window
data_store_i  input  DW  store data
data_load_o  output  DW  load data (combinational)
tx_o  output  1  serial line, idle high
busy_o  output  1  FIFO non-empty or frame in progress

Behaviour:
- Reset values (asynchronous assert):
  - tx_o=1, busy_o=0, FIFO empty, OVF=0, BAUD_DIV=DEFAULT_DIV, FSM=IDLE.
  - Counters and the shift register are 0.
- Register map by addr_i:
  - 0 TXDATA, write only: push data_store_i[7:0]; upper bits ignored; reads 0.
  - 1 STATUS, read: bit0 busy, bit1 full, bit2 empty, bit3 OVF; other bits 0.
  - 1 STATUS, write: data_store_i[3]=1 clears OVF; other bits ignored.
  - 2 BAUD_DIV, read/write: bits [15:0]; upper bits read 0.
  - 3 reserved: reads 0, writes ignored.
- Read path:
  - data_load_o is combinational from addr_i and current state.
  - data_load_o is 0 when cs_i=0.
- Write strobe: a write takes effect at the rising edge where cs_i&we_i=1.
- FIFO:
  - Circular buffer with wrapping read/write pointers and a count of width clog2(FIFO_DEPTH)+1.
  - Push when full and no pop in the same cycle: byte dropped, OVF set (sticky), contents unchanged.
  - Push and pop in the same cycle: always accepted, including when full; count unchanged.
  - Pop only happens from FSM IDLE.
- FSM IDLE:
  - tx_o=1.
  - If FIFO non-empty at an edge, pop the head into an 8-bit shift register.
  - Latch div_q = max(BAUD_DIV,1) and go to START.
  - A byte written at edge k is popped at edge k+1 if the FSM is idle.
- FSM START:
  - tx_o=0 for div_q clocks, then go to DATA with bit_cnt=0.
- FSM DATA:
  - tx_o = shift[0], LSB first.
  - Each bit lasts div_q clocks; shift right at each bit boundary.
  - After bit_cnt=7 completes, go to STOP.
- FSM STOP:
  - tx_o=1 for div_q clocks, then return to IDLE.
  - A next byte pops on the same edge the FSM enters IDLE, so there is one idle clock of tx_o=1 between back-to-back frames.
- Frame length: 10*div_q clocks plus 1 IDLE clock per frame.
- Baud counter:
  - Counts 0..div_q-1.
  - Terminal count advances the bit; the counter resets on every state change.
- Divisor changes:
  - A BAUD_DIV write mid-frame does not affect the current frame (div_q is latched); it applies to the next frame.
  - BAUD_DIV=0 behaves as 1.
- tx_o is driven from a flop (registered) to avoid glitches.
- busy_o = (FSM!=IDLE) | (count!=0); it matches STATUS bit0.
- Reset mid-frame:
  - tx_o returns high immediately (asynchronous).
  - FIFO contents are discarded; no partial frame resumes after release.
- Reads have no side effects; a STATUS read does not clear OVF.

Test Plan:
- Reset, BAUD_DIV=4, write 0x55 to offset 0 at edge k:
  - tx_o falls at edge k+1 and stays low 4 clocks.
  - Then bits 1,0,1,0,1,0,1,0 at 4 clocks each, then high for 4 clocks.
  - busy_o deasserts at edge k+41.
- BAUD_DIV=2, writes 0xA3 and 0x0F in consecutive cycles:
  - Two frames with exactly one idle-high clock between them.
  - Data bits 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
  - No overflow.
- BAUD_DIV=100, six back-to-back writes 0x01..0x06:
  - The 6th write is dropped and STATUS reads 0x0B (busy, full, OVF).
  - Bytes 0x01..0x05 are transmitted in order.
  - Write 0x8 to STATUS clears OVF.
- Read BAUD_DIV after reset: returns DEFAULT_DIV.
  - Write 0xFFFF_0010: readback 0x0010.
  - Write 0 to BAUD_DIV, then send 0xFF: each bit is 1 clock.
- Write BAUD_DIV=8 during a frame sent at BAUD_DIV=4:
  - Current frame keeps 4 clk/bit.
  - Next queued frame uses 8 clk/bit.
- Assert rst mid-DATA with 2 bytes queued:
  - tx_o goes to 1 immediately.
  - After release, STATUS reads 0x4 (empty) and no further frames appear.
  - cs_i=0 reads of any offset return 0.

Source files
------------

// File: rtl/uart_tx_periph.sv
// rtl/uart_tx_periph.sv - memory-mapped 8N1 UART transmitter with TX FIFO
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   cs_i          chip select from the peripheral bus
//   we_i          store strobe, qualified by cs_i
//   addr_i        word offset: 0 TXDATA, 1 STATUS, 2 BAUD_DIV, 3 reserved
//   data_store_i  store data
//   data_load_o   load data, combinational, 0 when cs_i=0
//   tx_o          registered serial line, idle high
//   busy_o        FIFO non-empty or frame in progress

module uart_tx_periph #(
    parameter int DW          = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int DEFAULT_DIV = 868
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs_i,
    input  logic          we_i,
    input  logic [1:0]    addr_i,
    input  logic [DW-1:0] data_store_i,
    output logic [DW-1:0] data_load_o,
    output logic          tx_o,
    output logic          busy_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ovf;

    logic [15:0]   baud_div;
    logic [15:0]   div_q;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          tx_q;
    logic          tx_d;

    logic          wr_en;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic          empty;
    logic          bit_done;
    logic          unused_bits;

    assign wr_en    = cs_i & we_i;
    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign push_req = wr_en && (addr_i == 2'd0);
    assign pop      = (state == S_IDLE) && !empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign push_ok  = push_req && (!full || pop);
    assign bit_done = (baud_cnt == div_q - 16'd1);
    assign unused_bits = ^data_store_i[DW-1:16];

    // FIFO storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_store_i[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full && !pop) begin
                ovf <= 1'b1;
            end else if (wr_en && (addr_i == 2'd1) && data_store_i[3]) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_div <= 16'(DEFAULT_DIV);
        end else if (wr_en && (addr_i == 2'd2)) begin
            baud_div <= data_store_i[15:0];
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (!empty) state_next = S_START;
            S_START: if (bit_done) state_next = S_DATA;
            S_DATA:  if (bit_done && (bit_cnt == 3'd7)) state_next = S_STOP;
            S_STOP:  if (bit_done) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM output logic: the value tx_o takes after this edge, so the line
    // changes on the same edge as the state and stays glitch-free.
    always_comb begin
        tx_d = 1'b1;
        case (state_next)
            S_START: tx_d = 1'b0;
            // Inside DATA a bit boundary shifts right, so the next bit is shift[1].
            S_DATA:  tx_d = (state == S_DATA && bit_done) ? shift[1] : shift[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q <= 1'b1;
        end else begin
            tx_q <= tx_d;
        end
    end

    // Baud counter, bit counter and shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            div_q    <= '0;
        end else begin
            // Every state change happens at terminal count or from IDLE,
            // so this also clears the counter on each transition.
            if (state == S_IDLE || bit_done) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
            if (pop) begin
                shift <= mem[rd_ptr];
                div_q <= (baud_div == 16'd0) ? 16'd1 : baud_div;
            end
            if (state == S_START && bit_done) begin
                bit_cnt <= '0;
            end
            if (state == S_DATA && bit_done) begin
                shift   <= {1'b0, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = (state != S_IDLE) || !empty;

    always_comb begin
        data_load_o = '0;
        if (cs_i) begin
            case (addr_i)
                2'd1:    data_load_o = DW'({ovf, empty, full, busy_o});
                2'd2:    data_load_o = DW'(baud_div);
                default: data_load_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb/tb_uart_tx_periph.sv - scoreboard testbench for uart_tx_periph

module tb_uart_tx_periph;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cs = 1'b0;
    logic          we = 1'b0;
    logic [1:0]    addr = 2'd0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          tx;
    logic          busy;

    uart_tx_periph #(
        .DW(DW),
        .FIFO_DEPTH(4),
        .DEFAULT_DIV(868)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cs_i(cs),
        .we_i(we),
        .addr_i(addr),
        .data_store_i(wdata),
        .data_load_o(rdata),
        .tx_o(tx),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         div;
        int         gap;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cycle = 0;
    bit   in_frame = 1'b0;

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = a; wdata = v;
        @(posedge clk);
        #1;
        cs = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; addr = a;
        #1;
        d = rdata;
        cs = 1'b0; addr = 2'd0;
    endtask

    task automatic expect_frame(input logic [7:0] b, input int d, input int g);
        exp_t e;
        e.data = b; e.div = d; e.gap = g;
        sb.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !in_frame && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1'b1);
    endtask

    // Monitor: decodes every frame on tx and compares it with the queue head.
    initial begin : monitor
        logic       prev_tx;
        exp_t       e;
        int         last_end;
        int         d;
        int         bi;
        bit         abort;
        bit         wf_ok;
        logic       exp_bit;
        logic [7:0] got;
        prev_tx  = 1'b1;
        last_end = -1000;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_tx = 1'b1;
            end else begin
                if (prev_tx && !tx) begin
                    if (sb.size() == 0) begin
                        check("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        d = e.div;
                        in_frame = 1'b1;
                        abort = 1'b0;
                        wf_ok = 1'b1;
                        got = 8'h00;
                        if (e.gap >= 0) check("frame_gap", cycle - last_end - 1, e.gap);
                        for (int i = 0; i < 10 * d; i++) begin
                            if (i > 0) @(negedge clk);
                            if (rst) begin
                                abort = 1'b1;
                                break;
                            end
                            bi = i / d;
                            exp_bit = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : e.data[bi-1];
                            if (tx !== exp_bit) wf_ok = 1'b0;
                            if (bi >= 1 && bi <= 8 && (i % d) == d / 2) got[bi-1] = tx;
                        end
                        if (abort) begin
                            sb.delete();
                        end else begin
                            check("frame_data", got, e.data);
                            check("frame_timing", wf_ok, 1'b1);
                            last_end = cycle;
                        end
                        in_frame = 1'b0;
                    end
                end
                prev_tx = tx;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] r;
        bit          stayed_high;

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        bus_read(2'd1, r); check("rst_status", r, 32'h4);
        bus_read(2'd2, r); check("rst_baud", r, 32'd868);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single frame at BAUD_DIV=4, exact start and busy timing
        bus_write(2'd2, 32'd4);
        expect_frame(8'h55, 4, -1);
        bus_write(2'd0, 32'h0000_0055);
        @(negedge clk); check("t1_tx_after_k", tx, 1'b1);
        @(negedge clk); check("t1_tx_after_k1", tx, 1'b0);
        repeat (39) @(negedge clk);
        check("t1_busy_k40", busy, 1'b1);
        @(negedge clk);
        check("t1_busy_k41", busy, 1'b0);
        drain("t1_drain", 200);

        // Back-to-back frames at BAUD_DIV=2
        bus_write(2'd2, 32'd2);
        expect_frame(8'hA3, 2, -1);
        expect_frame(8'h0F, 2, 1);
        bus_write(2'd0, 32'h0000_00A3);
        bus_write(2'd0, 32'hFFFF_FF0F);
        drain("t2_drain", 200);
        bus_read(2'd1, r); check("t2_status", r, 32'h4);

        // Overflow at BAUD_DIV=100
        bus_write(2'd2, 32'd100);
        expect_frame(8'h01, 100, -1);
        for (int v = 2; v <= 5; v++) expect_frame(8'(v), 100, 1);
        for (int v = 1; v <= 6; v++) bus_write(2'd0, 32'(v));
        bus_read(2'd1, r); check("t3_status_ovf", r, 32'h0B);
        bus_read(2'd1, r); check("t3_status_reread", r, 32'h0B);
        bus_write(2'd1, 32'h8);
        bus_read(2'd1, r); check("t3_status_clr", r, 32'h03);
        drain("t3_drain", 6000);
        bus_read(2'd1, r); check("t3_status_end", r, 32'h4);

        // BAUD_DIV masking, zero divisor, reserved offsets
        bus_write(2'd2, 32'hFFFF_0010);
        bus_read(2'd2, r); check("t4_baud_mask", r, 32'h10);
        bus_write(2'd3, 32'hDEAD_BEEF);
        bus_read(2'd3, r); check("t4_reserved", r, 32'h0);
        bus_read(2'd0, r); check("t4_txdata_read", r, 32'h0);
        bus_write(2'd2, 32'd0);
        bus_read(2'd2, r); check("t4_baud_zero", r, 32'h0);
        expect_frame(8'hFF, 1, -1);
        bus_write(2'd0, 32'hFF);
        drain("t4_drain", 100);

        // Divisor change mid-frame applies to the next frame only
        bus_write(2'd2, 32'd4);
        expect_frame(8'h3C, 4, -1);
        expect_frame(8'hC5, 8, 1);
        bus_write(2'd0, 32'h3C);
        bus_write(2'd0, 32'hC5);
        repeat (10) @(negedge clk);
        bus_write(2'd2, 32'd8);
        bus_read(2'd2, r); check("t5_baud", r, 32'd8);
        drain("t5_drain", 300);

        // Reset in the middle of DATA with two bytes queued
        bus_write(2'd2, 32'd4);
        expect_frame(8'h5A, 4, -1);
        expect_frame(8'h11, 4, 1);
        expect_frame(8'h22, 4, 1);
        bus_write(2'd0, 32'h5A);
        bus_write(2'd0, 32'h11);
        bus_write(2'd0, 32'h22);
        repeat (12) @(negedge clk);
        check("t6_tx_low_before_rst", tx, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("t6_tx_async", tx, 1'b1);
        check("t6_busy_async", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus_read(2'd1, r); check("t6_status", r, 32'h4);
        check("t6_sb_cleared", sb.size(), 32'd0);
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            check($sformatf("t6_cs0_read%0d", a), rdata, 32'h0);
        end
        addr = 2'd0;
        stayed_high = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) stayed_high = 1'b0;
        end
        check("t6_no_frames", stayed_high, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
